// File: rtl/serialtopara_lane.sv
// Serial-to-parallel lane: hunts for the idle comma, locks byte phase, then strobes one byte per 8 bit clocks.
// Optional build macro SERIALTOPARA_REALIGN_EN re-phases the lane on an off-boundary comma while ACTIVE.
module serialtopara_lane #(
  parameter logic [7:0] COMMA        = 8'hBC,
  parameter int         ACTIVE_COUNT = 4
) (
  input  logic       clk8f,
  input  logic       reset,
  input  logic       data_in,
  output logic [7:0] data_out,
  output logic       valid_out,
  output logic       byte_stb,
  output logic       active
);

  typedef enum logic [1:0] {HUNT, ALIGN, ACTIVE} state_t;

  localparam logic [3:0] LOCK_COUNT = 4'(ACTIVE_COUNT);

  state_t     state_reg, state_next;
  logic [7:0] shift_reg, shift_next;
  logic [2:0] bit_cnt_reg, bit_cnt_next;
  logic [3:0] bc_cnt_reg, bc_cnt_next;
  logic [7:0] data_reg, data_next;
  logic       valid_reg, valid_next;
  logic       stb_reg, stb_next;
  logic       active_reg, active_next;
  logic       is_comma;
  logic       boundary;

  always_ff @(posedge clk8f or posedge reset) begin
    if (reset) begin
      state_reg   <= HUNT;
      shift_reg   <= 8'h00;
      bit_cnt_reg <= 3'd0;
      bc_cnt_reg  <= 4'd0;
      data_reg    <= 8'h00;
      valid_reg   <= 1'b0;
      stb_reg     <= 1'b0;
      active_reg  <= 1'b0;
    end else begin
      state_reg   <= state_next;
      shift_reg   <= shift_next;
      bit_cnt_reg <= bit_cnt_next;
      bc_cnt_reg  <= bc_cnt_next;
      data_reg    <= data_next;
      valid_reg   <= valid_next;
      stb_reg     <= stb_next;
      active_reg  <= active_next;
    end
  end

  always_comb begin
    shift_next   = {shift_reg[6:0], data_in};
    is_comma     = (shift_next == COMMA);
    boundary     = (bit_cnt_reg == 3'd7);
    state_next   = state_reg;
    bit_cnt_next = bit_cnt_reg;
    bc_cnt_next  = bc_cnt_reg;
    data_next    = data_reg;
    valid_next   = valid_reg;
    stb_next     = 1'b0;
    active_next  = active_reg;

    case (state_reg)
      HUNT: begin
        // The edge completing a comma defines the byte phase.
        if (is_comma) begin
          bit_cnt_next = 3'd0;
          bc_cnt_next  = 4'd1;
          if (ACTIVE_COUNT == 1) begin
            state_next  = ACTIVE;
            active_next = 1'b1;
          end else begin
            state_next = ALIGN;
          end
        end
      end

      ALIGN: begin
        bit_cnt_next = bit_cnt_reg + 3'd1;
        if (boundary) begin
          if (is_comma) begin
            bc_cnt_next = bc_cnt_reg + 4'd1;
            if (bc_cnt_reg + 4'd1 == LOCK_COUNT) begin
              state_next  = ACTIVE;
              active_next = 1'b1;
            end
          end else begin
            state_next  = HUNT;
            bc_cnt_next = 4'd0;
          end
        end
      end

      ACTIVE: begin
        bit_cnt_next = bit_cnt_reg + 3'd1;
        if (boundary) begin
          stb_next = 1'b1;
          // Commas are idle: report them as not-valid and keep the last data byte.
          if (is_comma) begin
            valid_next = 1'b0;
          end else begin
            valid_next = 1'b1;
            data_next  = shift_next;
          end
        end
`ifdef SERIALTOPARA_REALIGN_EN
        else if (is_comma) begin
          bit_cnt_next = 3'd0;
          bc_cnt_next  = 4'd1;
          if (ACTIVE_COUNT == 1) begin
            active_next = 1'b1;
          end else begin
            state_next  = ALIGN;
            active_next = 1'b0;
          end
        end
`endif
      end

      default: begin
        state_next = HUNT;
      end
    endcase
  end

  assign data_out  = data_reg;
  assign valid_out = valid_reg;
  assign byte_stb  = stb_reg;
  assign active    = active_reg;

endmodule

// File: tb/tb_serialtopara_lane.sv
// Bench for serialtopara_lane: directed scenarios plus random streams against an edge-indexed reference model.
module tb_serialtopara_lane;

  localparam logic [7:0] COMMA = 8'hBC;
  localparam int         AC    = 4;

  logic       clk8f = 1'b0;
  logic       reset = 1'b1;
  logic       data_in = 1'b0;
  logic [7:0] data_out;
  logic       valid_out;
  logic       byte_stb;
  logic       active;

  int total = 0;
  int bad = 0;

  // Reference model: byte phase is tracked as the edge index of the comma that set it.
  logic [7:0] m_win;
  int         m_edge;
  int         m_anchor;
  int         m_ncomma;
  bit         m_lock;
  logic       m_stb;
  logic       m_valid;
  logic [7:0] m_data;

  serialtopara_lane #(.COMMA(COMMA), .ACTIVE_COUNT(AC)) dut (
    .clk8f(clk8f),
    .reset(reset),
    .data_in(data_in),
    .data_out(data_out),
    .valid_out(valid_out),
    .byte_stb(byte_stb),
    .active(active)
  );

  always #5 clk8f = ~clk8f;

  function void model_reset();
    m_win    = 8'h00;
    m_edge   = 0;
    m_anchor = 0;
    m_ncomma = 0;
    m_lock   = 1'b0;
    m_stb    = 1'b0;
    m_valid  = 1'b0;
    m_data   = 8'h00;
  endfunction

  function void model_step(input logic b);
    m_win  = {m_win[6:0], b};
    m_edge = m_edge + 1;
    m_stb  = 1'b0;
    if (!m_lock) begin
      if (m_ncomma == 0) begin
        if (m_win == COMMA) begin
          m_anchor = m_edge;
          m_ncomma = 1;
          m_lock   = (AC == 1);
        end
      end else if ((m_edge - m_anchor) % 8 == 0) begin
        if (m_win == COMMA) begin
          m_ncomma = m_ncomma + 1;
          if (m_ncomma == AC) m_lock = 1'b1;
        end else begin
          m_ncomma = 0;
        end
      end
    end else begin
      if ((m_edge - m_anchor) % 8 == 0) begin
        m_stb = 1'b1;
        if (m_win == COMMA) begin
          m_valid = 1'b0;
        end else begin
          m_valid = 1'b1;
          m_data  = m_win;
        end
      end
`ifdef SERIALTOPARA_REALIGN_EN
      else if (m_win == COMMA) begin
        m_anchor = m_edge;
        m_ncomma = 1;
        m_lock   = (AC == 1);
      end
`endif
    end
  endfunction

  task automatic send_bit(input logic b);
    data_in = b;
    @(posedge clk8f);
    #1;
    model_step(b);
  endtask

  task automatic send_byte(input logic [7:0] v);
    for (int i = 7; i >= 0; i--) send_bit(v[i]);
  endtask

  task automatic do_reset();
    @(posedge clk8f);
    #2 reset = 1'b1;
    @(posedge clk8f);
    #2 reset = 1'b0;
    model_reset();
  endtask

  task automatic lock_link();
    do_reset();
    repeat (AC) send_byte(COMMA);
  endtask

  task automatic test_reset();
    logic [7:0] nib;
    lock_link();
    send_byte(8'hA5);
    total++;
    if (data_out !== 8'hA5 || valid_out !== 1'b1) begin
      bad++;
      $display("FAIL reset_pre_data: got data=%h valid=%b want data=a5 valid=1", data_out, valid_out);
    end
    nib = 8'h3C;
    for (int i = 7; i >= 4; i--) send_bit(nib[i]);
    #2 reset = 1'b1;
    #1;
    total++;
    if (active !== 1'b0) begin bad++; $display("FAIL reset_active: got %b want 0", active); end
    total++;
    if (byte_stb !== 1'b0) begin bad++; $display("FAIL reset_stb: got %b want 0", byte_stb); end
    total++;
    if (valid_out !== 1'b0) begin bad++; $display("FAIL reset_valid: got %b want 0", valid_out); end
    total++;
    if (data_out !== 8'h00) begin bad++; $display("FAIL reset_data: got %h want 00", data_out); end
    @(posedge clk8f);
    #2 reset = 1'b0;
    model_reset();
    repeat (AC - 1) send_byte(COMMA);
    total++;
    if (active !== 1'b0) begin bad++; $display("FAIL reset_rehunt_early: got active=%b want 0", active); end
    send_byte(COMMA);
    total++;
    if (active !== 1'b1) begin bad++; $display("FAIL reset_rehunt_lock: got active=%b want 1", active); end
  endtask

  task automatic test_lock();
    logic [7:0] c;
    int stb_cnt;
    c = COMMA;
    stb_cnt = 0;
    do_reset();
    send_bit(1'b1); stb_cnt += int'(byte_stb);
    send_bit(1'b0); stb_cnt += int'(byte_stb);
    send_bit(1'b1); stb_cnt += int'(byte_stb);
    for (int k = 0; k < AC * 8; k++) begin
      send_bit(c[7 - (k % 8)]);
      stb_cnt += int'(byte_stb);
      if (k == 23 || k == 30) begin
        total++;
        if (active !== 1'b0) begin bad++; $display("FAIL lock_early bit=%0d: got active=%b want 0", k, active); end
      end
    end
    total++;
    if (active !== 1'b1) begin bad++; $display("FAIL lock_active: got %b want 1", active); end
    total++;
    if (stb_cnt !== 0) begin bad++; $display("FAIL lock_no_stb: got %0d strobes want 0", stb_cnt); end
  endtask

  task automatic test_data();
    logic [7:0] bytes [3];
    int stray;
    bytes[0] = 8'hAA; bytes[1] = 8'hEE; bytes[2] = 8'hEE;
    stray = 0;
    lock_link();
    for (int n = 0; n < 3; n++) begin
      for (int i = 7; i >= 0; i--) begin
        send_bit(bytes[n][i]);
        if (i != 0) begin
          if (byte_stb !== 1'b0) stray++;
        end else begin
          total++;
          if (byte_stb !== 1'b1 || valid_out !== 1'b1 || data_out !== bytes[n]) begin
            bad++;
            $display("FAIL data_byte%0d: got stb=%b valid=%b data=%h want stb=1 valid=1 data=%h",
                     n, byte_stb, valid_out, data_out, bytes[n]);
          end
        end
      end
    end
    send_bit(1'b0);
    if (byte_stb !== 1'b0) stray++;
    total++;
    if (stray !== 0) begin bad++; $display("FAIL data_period: got %0d off-boundary strobes want 0", stray); end
  endtask

  task automatic test_idle();
    lock_link();
    send_byte(8'hEE);
    send_byte(COMMA);
    total++;
    if (byte_stb !== 1'b1 || valid_out !== 1'b0 || data_out !== 8'hEE) begin
      bad++;
      $display("FAIL idle_comma: got stb=%b valid=%b data=%h want stb=1 valid=0 data=ee", byte_stb, valid_out, data_out);
    end
    send_byte(8'hBB);
    total++;
    if (byte_stb !== 1'b1 || valid_out !== 1'b1 || data_out !== 8'hBB) begin
      bad++;
      $display("FAIL idle_after: got stb=%b valid=%b data=%h want stb=1 valid=1 data=bb", byte_stb, valid_out, data_out);
    end
  endtask

  task automatic test_failed_align();
    do_reset();
    send_byte(COMMA);
    send_byte(COMMA);
    send_byte(8'h55);
    total++;
    if (active !== 1'b0) begin bad++; $display("FAIL falign_55: got active=%b want 0", active); end
    repeat (AC - 1) send_byte(COMMA);
    total++;
    if (active !== 1'b0) begin bad++; $display("FAIL falign_early: got active=%b want 0", active); end
    send_byte(COMMA);
    total++;
    if (active !== 1'b1) begin bad++; $display("FAIL falign_lock: got active=%b want 1", active); end
  endtask

  task automatic push_byte(inout logic q[$], input logic [7:0] v);
    for (int i = 7; i >= 0; i--) q.push_back(v[i]);
  endtask

  task automatic run_checked(input string tag, input logic q[$]);
    for (int j = 0; j < q.size(); j++) begin
      send_bit(q[j]);
      total++;
      if (active !== m_lock) begin bad++; $display("FAIL %s_active edge=%0d: got %b want %b", tag, j, active, m_lock); end
      total++;
      if (byte_stb !== m_stb) begin bad++; $display("FAIL %s_stb edge=%0d: got %b want %b", tag, j, byte_stb, m_stb); end
      total++;
      if (valid_out !== m_valid) begin bad++; $display("FAIL %s_valid edge=%0d: got %b want %b", tag, j, valid_out, m_valid); end
      total++;
      if (data_out !== m_data) begin bad++; $display("FAIL %s_data edge=%0d: got %h want %h", tag, j, data_out, m_data); end
    end
  endtask

  task automatic test_realign();
    logic q[$];
    logic [7:0] c;
    c = COMMA;
    push_byte(q, 8'hAA);
    q.push_back(1'b0); q.push_back(1'b0); q.push_back(1'b0);
    repeat (4) push_byte(q, COMMA);
    push_byte(q, 8'h5A);
    lock_link();
    for (int j = 0; j < q.size(); j++) begin
      send_bit(q[j]);
      total++;
      if (active !== m_lock || byte_stb !== m_stb || valid_out !== m_valid || data_out !== m_data) begin
        bad++;
        $display("FAIL realign_model edge=%0d: got act=%b stb=%b v=%b d=%h want act=%b stb=%b v=%b d=%h",
                 j, active, byte_stb, valid_out, data_out, m_lock, m_stb, m_valid, m_data);
      end
      if (j == 15) begin
        total++;
        if (byte_stb !== 1'b1 || data_out !== 8'h17) begin
          bad++; $display("FAIL realign_oldphase: got stb=%b data=%h want stb=1 data=17", byte_stb, data_out);
        end
      end
`ifdef SERIALTOPARA_REALIGN_EN
      if (j == 18) begin
        total++;
        if (active !== 1'b0) begin bad++; $display("FAIL realign_drop: got active=%b want 0", active); end
      end
      if (j == 50) begin
        total++;
        if (byte_stb !== 1'b1 || data_out !== 8'h5A) begin
          bad++; $display("FAIL realign_newphase: got stb=%b data=%h want stb=1 data=5a", byte_stb, data_out);
        end
      end
`else
      if (j == 18) begin
        total++;
        if (active !== 1'b1) begin bad++; $display("FAIL realign_keep: got active=%b want 1", active); end
      end
      if (j == 23) begin
        total++;
        if (byte_stb !== 1'b1 || data_out !== 8'h97) begin
          bad++; $display("FAIL realign_oldphase2: got stb=%b data=%h want stb=1 data=97", byte_stb, data_out);
        end
      end
`endif
      if (j == 42) begin
        total++;
        if (active !== 1'b1) begin bad++; $display("FAIL realign_relock: got active=%b want 1", active); end
      end
    end
    if (c != COMMA) $display("comma constant changed");
  endtask

  task automatic test_random();
    for (int r = 0; r < 3; r++) begin
      logic q[$];
      int lead;
      q = {};
      lead = $urandom_range(0, 7);
      for (int i = 0; i < lead; i++) q.push_back(1'($urandom_range(0, 1)));
      repeat (AC) push_byte(q, COMMA);
      for (int n = 0; n < 30; n++) begin
        if ($urandom_range(0, 3) == 0) push_byte(q, COMMA);
        else push_byte(q, 8'($urandom));
      end
      do_reset();
      run_checked("random", q);
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_lock();
    test_data();
    test_idle();
    test_failed_align();
    test_realign();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not finish within bound");
    $fatal(1);
  end

endmodule

// File: doc/serialtopara_lane.md
# serialtopara_lane

- Downstream stage of the paratoserial serializer.
- Receives one serial lane MSB-first on the bit clock and recovers byte alignment by hunting for the 0xBC idle comma.
- Declares the link active after a run of aligned commas, then emits one byte per 8 bit-clocks with a strobe.
- Idle commas become `valid_out` = 0; all other bytes are reported as valid data to the downstream demux.

## Interface
- COMMA, 8'hBC, idle/alignment symbol the serializer sends when its valid is low
- ACTIVE_COUNT, 4, consecutive aligned commas required to assert `active` (legal range 1..15)
- clk8f  input  1  bit clock, one serial bit per rising edge
- reset  input  1  asynchronous, active-high; clears all state immediately
- data_in  input  1  serial bit, MSB of each byte first
- data_out  output  8  last recovered non-comma byte
- valid_out  output  1  1 = byte at current strobe is data, 0 = comma/idle
- byte_stb  output  1  one-cycle pulse per recovered byte, ACTIVE state only
- active  output  1  link locked and reporting bytes

## Operation
- `shift_next` = {shift[6:0], data_in}; `shift` <= `shift_next` every edge in every state.
- A 3-bit `bit_cnt` marks byte boundaries. A boundary edge is an edge with `bit_cnt` == 7.
- A 4-bit `bc_cnt` counts aligned commas.
- States: HUNT, ALIGN, ACTIVE.
- HUNT: every edge, test `shift_next` == COMMA.
  - On a match: `bit_cnt` <= 0 and `bc_cnt` <= 1.
  - If ACTIVE_COUNT == 1, go to ACTIVE and set `active` <= 1; otherwise go to ALIGN.
- ALIGN: `bit_cnt` increments and wraps 7 -> 0. On each boundary edge:
  - `shift_next` == COMMA: `bc_cnt` += 1. When `bc_cnt` reaches ACTIVE_COUNT, go to ACTIVE and set `active` <= 1.
  - Any other byte: go to HUNT and set `bc_cnt` <= 0.
- ACTIVE: on each boundary edge, `byte_stb` <= 1.
  - `shift_next` == COMMA: `valid_out` <= 0 and `data_out` holds its value.
  - Otherwise: `valid_out` <= 1 and `data_out` <= `shift_next`.
  - Non-comma bytes never drop lock.
  - A genuine data byte equal to COMMA is indistinguishable from idle and is reported with `valid_out` = 0.
- `byte_stb` is 0 on all non-boundary edges. `valid_out` and `data_out` hold between strobes.
- `active` stays 1 until reset. With SERIALTOPARA_REALIGN_EN, a realign event also clears it.

## Timing
- Reset values:
  - `data_out` = 8'h00; `valid_out`, `byte_stb`, `active` = 0.
  - `shift` = 0, `bit_cnt` = 0, `bc_cnt` = 0, state = HUNT.
- Reset is asynchronous: outputs clear without waiting for a clock edge, including mid-byte or mid-ALIGN.
- The first edge with reset low samples bit 7 of the next byte.
- Latency: a byte's outputs update on the same edge that samples its LSB, and are visible for the following cycle.
- `byte_stb` period is exactly 8 `clk8f` cycles while ACTIVE.
- Lock time from the first comma's LSB to `active` is (ACTIVE_COUNT - 1) × 8 edges. With the default this is 24 edges after the first comma completes.
- Since `shift` resets to 0, the earliest possible HUNT match is the 8th edge after reset release.

## Configuration
- SERIALTOPARA_REALIGN_EN defined:
  - In ACTIVE, on a non-boundary edge where `shift_next` == COMMA, the block re-phases.
  - `bit_cnt` <= 0, `bc_cnt` <= 1, `active` <= 0, `byte_stb` <= 0, and state goes to ALIGN (directly to ACTIVE if ACTIVE_COUNT == 1).
  - `data_out` and `valid_out` hold.
  - Accepted risk: data bit patterns spanning two bytes that form COMMA trigger a false realign.
- SERIALTOPARA_REALIGN_EN undefined: off-boundary comma matches in ACTIVE are ignored and lock is permanent until reset.

## Test plan
1. Reset: lock the link, then raise reset mid-byte (bit 3).
   - `active`, `byte_stb`, `valid_out` fall to 0 and `data_out` = 00 before the next edge.
   - After release, state is HUNT.
2. Lock: 3 garbage bits (101), then 4 × BC MSB-first.
   - `active` rises on the edge sampling the LSB of the 4th BC.
   - No `byte_stb` pulses before that edge.
3. Data: after lock, send AA, EE, EE.
   - Three `byte_stb` pulses exactly 8 cycles apart.
   - Values: `data_out` = AA, EE, EE with `valid_out` = 1.
4. Idle insertion: after lock, send EE, BC, BB.
   - At the BC strobe: `valid_out` = 0 and `data_out` stays EE.
   - Next strobe: `data_out` = BB, `valid_out` = 1.
5. Failed alignment: BC, BC, 55, then 4 × BC.
   - On the 55 boundary, the block returns to HUNT with `active` = 0.
   - Lock completes only after the later 4 × BC.
6. Macro: after lock, insert 3 extra bits, then 4 × BC.
   - With SERIALTOPARA_REALIGN_EN: `active` drops on the misaligned BC LSB and re-asserts after 3 more aligned BCs.
   - Without the macro: `active` stays 1 and strobes keep the old phase.
